// File: rtl/cpu_ctrl.sv
// cpu_ctrl: fetch/decode/execute sequencer, PC, IR and return stack for the 8-bit RISC CPU.
// Optional CTRL_STACK_CHK_EN: trap ACL-when-full / RET-when-empty into S_HALT with sticky stack_err.
module cpu_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [7:0]        data_in,
    output logic [ADDR_W-1:0] addr,
    output logic              rd,
    output logic              wr,
    output logic              datactl_ena,
    output logic [3:0]        alu_op,
    output logic              load_acc,
    output logic              halt,
`ifdef CTRL_STACK_CHK_EN
    output logic              stack_err,
`endif
    output logic [ADDR_W-1:0] pc
);

    localparam int SP_W = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_F0, S_F1, S_DEC, S_EX, S_WB, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP, OP_LDO, OP_LDA, OP_STO,
        OP_PRE, OP_JMP, OP_ADD, OP_SUB,
        OP_LAND, OP_LOR, OP_LNOT, OP_INC,
        OP_ACL, OP_RET, OP_LDM, OP_HLT
    } op_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       ir_q, ir_d;
    logic [SP_W-1:0]   sp_q, sp_d, sp_m1;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              dc_q, dc_d;
    logic              ld_q, ld_d;
    logic              halt_q, halt_d;
    logic [3:0]        alu_q, alu_d;
    op_e               op, op_n;
    logic [ADDR_W-1:0] ir_addr, ir_addr_n;
    logic              bus_n, acc_n, sto_n;
    logic              stk_trap;

    assign op        = op_e'(ir_q[15:12]);
    assign ir_addr   = ir_q[ADDR_W-1:0];
    assign op_n      = op_e'(ir_d[15:12]);
    assign ir_addr_n = ir_d[ADDR_W-1:0];
    assign sp_m1     = sp_q - SP_W'(1);

`ifdef CTRL_STACK_CHK_EN
    logic [SP_W:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    assign stk_trap = (state_q == S_EX) &&
        (((op == OP_ACL) && (cnt_q == (SP_W+1)'(STACK_DEPTH))) ||
         ((op == OP_RET) && (cnt_q == '0)));
    assign err_d     = err_q | stk_trap;
    assign stack_err = err_q;
`else
    assign stk_trap = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_F0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; S_F0 advances only once a fetch strobe is on the bus
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_F0:    if (rd_q) state_d = S_F1;
            S_F1:    state_d = S_DEC;
            S_DEC:   state_d = (op == OP_HLT) ? S_HALT : S_EX;
            S_EX:    state_d = stk_trap ? S_HALT : S_WB;
            S_WB:    state_d = S_F0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_F0;
        endcase
    end

    // PC, IR and return stack
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        sp_d    = sp_q;
        stack_d = stack_q;
`ifdef CTRL_STACK_CHK_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            S_F0: begin
                if (rd_q) begin
                    ir_d[15:8] = data_in;
                    pc_d       = pc_q + ADDR_W'(1);
                end
            end
            S_F1: begin
                ir_d[7:0] = data_in;
                pc_d      = pc_q + ADDR_W'(1);
            end
            S_EX: begin
                if (!stk_trap) begin
                    case (op)
                        OP_JMP: pc_d = ir_addr;
                        OP_ACL: begin
                            stack_d[sp_q] = pc_q;
                            sp_d          = sp_q + SP_W'(1);
                            pc_d          = ir_addr;
`ifdef CTRL_STACK_CHK_EN
                            cnt_d         = cnt_q + 1'b1;
`endif
                        end
                        OP_RET: begin
                            sp_d = sp_m1;
                            pc_d = stack_q[sp_m1];
`ifdef CTRL_STACK_CHK_EN
                            cnt_d = cnt_q - 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Outputs are registered: decode them for the state being entered
    always_comb begin
        bus_n = op_n inside {OP_LDO, OP_LDA, OP_PRE, OP_ADD,
                             OP_SUB, OP_LAND, OP_LOR};
        acc_n = op_n inside {OP_LNOT, OP_INC};
        sto_n = (op_n == OP_STO);
        addr_d = addr_q;
        rd_d   = 1'b0;
        wr_d   = 1'b0;
        dc_d   = 1'b0;
        ld_d   = 1'b0;
        halt_d = 1'b0;
        alu_d  = 4'b0000;
        unique case (state_d)
            S_F0: begin
                rd_d   = ena;
                addr_d = pc_d;
            end
            S_F1: begin
                rd_d   = 1'b1;
                addr_d = pc_d;
            end
            S_DEC: alu_d = op_n;
            S_EX: begin
                alu_d = op_n;
                if (bus_n) begin
                    rd_d   = 1'b1;
                    addr_d = ir_addr_n;
                end else if (sto_n) begin
                    wr_d   = 1'b1;
                    dc_d   = 1'b1;
                    addr_d = ir_addr_n;
                end
            end
            S_WB: begin
                alu_d = op_n;
                if (bus_n) begin
                    rd_d   = 1'b1;
                    ld_d   = 1'b1;
                    addr_d = ir_addr_n;
                end else if (acc_n) begin
                    ld_d = 1'b1;
                end
            end
            S_HALT: halt_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            ir_q    <= '0;
            sp_q    <= '0;
            stack_q <= '{default: '0};
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            dc_q    <= 1'b0;
            ld_q    <= 1'b0;
            halt_q  <= 1'b0;
            alu_q   <= 4'b0000;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            sp_q    <= sp_d;
            stack_q <= stack_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            dc_q    <= dc_d;
            ld_q    <= ld_d;
            halt_q  <= halt_d;
            alu_q   <= alu_d;
        end
    end

`ifdef CTRL_STACK_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

    assign addr        = addr_q;
    assign rd          = rd_q;
    assign wr          = wr_q;
    assign datactl_ena = dc_q;
    assign load_acc    = ld_q;
    assign halt        = halt_q;
    assign alu_op      = alu_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: directed scoreboard bench for cpu_ctrl.
// Expected bus cycles are queued as instructions are planted, popped once per clock.
module tb_cpu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic [7:0]  data_in;
    logic [11:0] addr, pc;
    logic        rd, wr, datactl_ena, load_acc, halt;
    logic [3:0]  alu_op;
`ifdef CTRL_STACK_CHK_EN
    logic        stack_err;
`endif

    logic [7:0] mem [4096];
    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        ac;
        logic [11:0] a;
        logic        r;
        logic        w;
        logic        d;
        logic [3:0]  op;
        logic        l;
        logic        h;
    } cyc_t;

    cyc_t sb[$];

    cpu_ctrl dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .data_in(data_in),
        .addr(addr),
        .rd(rd),
        .wr(wr),
        .datactl_ena(datactl_ena),
        .alu_op(alu_op),
        .load_acc(load_acc),
        .halt(halt),
`ifdef CTRL_STACK_CHK_EN
        .stack_err(stack_err),
`endif
        .pc(pc)
    );

    always #5 clk = ~clk;

    assign data_in = rd ? mem[addr] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic cyc_t cy(input logic ac, input logic [11:0] a,
                                input logic r, input logic w, input logic d,
                                input logic [3:0] op, input logic l,
                                input logic h);
        cyc_t c;
        c.ac = ac; c.a = a; c.r = r; c.w = w; c.d = d;
        c.op = op; c.l = l; c.h = h;
        return c;
    endfunction

    // Write one instruction and queue its expected five bus cycles
    task automatic plant(input logic [11:0] fa, input logic [7:0] b0,
                         input logic [7:0] b1);
        logic [3:0]  op;
        logic [11:0] ia;
        logic        bus;
        mem[fa] = b0;
        mem[fa + 12'd1] = b1;
        op = b0[7:4];
        ia = {b0[3:0], b1};
        bus = op inside {4'h1, 4'h2, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9};
        sb.push_back(cy(1'b1, fa, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0));
        sb.push_back(cy(1'b1, fa + 12'd1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0));
        sb.push_back(cy(1'b0, 12'h0, 1'b0, 1'b0, 1'b0, op, 1'b0, 1'b0));
        if (op == 4'hF) return;
        if (bus) begin
            sb.push_back(cy(1'b1, ia, 1'b1, 1'b0, 1'b0, op, 1'b0, 1'b0));
            sb.push_back(cy(1'b1, ia, 1'b1, 1'b0, 1'b0, op, 1'b1, 1'b0));
        end else if (op == 4'h3) begin
            sb.push_back(cy(1'b1, ia, 1'b0, 1'b1, 1'b1, op, 1'b0, 1'b0));
            sb.push_back(cy(1'b0, 12'h0, 1'b0, 1'b0, 1'b0, op, 1'b0, 1'b0));
        end else begin
            sb.push_back(cy(1'b0, 12'h0, 1'b0, 1'b0, 1'b0, op, 1'b0, 1'b0));
            sb.push_back(cy(1'b0, 12'h0, 1'b0, 1'b0, 1'b0, op,
                            (op == 4'hA || op == 4'hB), 1'b0));
        end
    endtask

    task automatic push_halt(input int n);
        for (int i = 0; i < n; i++)
            sb.push_back(cy(1'b0, 12'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1));
    endtask

    task automatic push_idle(input int n, input logic [11:0] a);
        for (int i = 0; i < n; i++)
            sb.push_back(cy(1'b1, a, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0));
    endtask

    task automatic step(input int n);
        cyc_t e, o;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                o = cy(e.ac, e.ac ? addr : 12'h0, rd, wr, datactl_ena,
                       alu_op, load_acc, halt);
                if (!e.ac) e.a = 12'h0;
                chk($sformatf("cycle@%0t", $time), {6'b0, o}, {6'b0, e});
            end
        end
    endtask

    task automatic do_reset(input logic e);
        rst_n = 1'b0;
        ena = e;
        sb.delete();
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_strobes",
            32'({rd, wr, datactl_ena, load_acc, halt, alu_op}), 32'd0);
        chk("rst_addr_pc", 32'({addr, pc}), 32'd0);
`ifdef CTRL_STACK_CHK_EN
        chk("rst_stack_err", 32'(stack_err), 32'd0);
`endif
        rst_n = 1'b1;
    endtask

    initial begin
        // LDA/STO/JMP then ALU-only ops
        do_reset(1'b1);
        mem[12'h010] = 8'h5A;
        plant(12'h000, 8'h20, 8'h10);
        plant(12'h002, 8'h30, 8'h20);
        plant(12'h004, 8'h51, 8'h23);
        plant(12'h123, 8'hB0, 8'h00);
        plant(12'h125, 8'hA0, 8'h00);
        plant(12'h127, 8'h00, 8'h00);
        plant(12'h129, 8'hE0, 8'h00);
        step(3);
        chk("lda_pc", 32'(pc), 32'h002);
        step(32);
        chk("p1_pc", 32'(pc), 32'h12B);
        chk("p1_drained", 32'(sb.size()), 32'd0);

        // ACL/RET round trip then HLT with ena toggling
        do_reset(1'b1);
        plant(12'h000, 8'h50, 8'h10);
        plant(12'h010, 8'hC2, 8'h00);
        plant(12'h200, 8'hD0, 8'h00);
        plant(12'h012, 8'hF0, 8'h00);
        push_halt(20);
        step(18);
        for (int i = 0; i < 20; i++) begin
            step(1);
            ena = ~ena;
        end
        chk("halt_pc", 32'(pc), 32'h014);

        // ena low in S_F0 holds fetch; ena low mid-instruction is ignored
        do_reset(1'b0);
        push_idle(3, 12'h000);
        step(3);
        chk("idle_pc", 32'(pc), 32'h000);
        ena = 1'b1;
        plant(12'h000, 8'h00, 8'h00);
        plant(12'h002, 8'hB0, 8'h00);
        step(2);
        ena = 1'b0;
        step(3);
        ena = 1'b1;
        step(5);
        chk("ena_pc", 32'(pc), 32'h004);
        chk("ena_drained", 32'(sb.size()), 32'd0);

        // Five nested ACL on a four-deep stack
        do_reset(1'b1);
        plant(12'h000, 8'hC1, 8'h00);
        plant(12'h100, 8'hC2, 8'h00);
        plant(12'h200, 8'hC3, 8'h00);
        plant(12'h300, 8'hC4, 8'h00);
        plant(12'h400, 8'hC5, 8'h00);
`ifdef CTRL_STACK_CHK_EN
        void'(sb.pop_back());
        push_halt(3);
        step(27);
        chk("ovf_pc", 32'(pc), 32'h402);
        chk("ovf_stack_err", 32'(stack_err), 32'd1);
`else
        plant(12'h500, 8'hD0, 8'h00);
        plant(12'h402, 8'hD0, 8'h00);
        plant(12'h302, 8'hD0, 8'h00);
        plant(12'h202, 8'hD0, 8'h00);
        plant(12'h102, 8'hD0, 8'h00);
        plant(12'h402, 8'hD0, 8'h00);
        step(55);
`endif
        chk("ovf_drained", 32'(sb.size()), 32'd0);

        // PC wrap on byte1 fetch, then reset abort during STO write
        do_reset(1'b1);
        plant(12'h000, 8'h5F, 8'hFF);
        plant(12'hFFF, 8'h30, 8'h5F);
        step(9);
        rst_n = 1'b0;
        #1;
        chk("abort_wr", 32'({wr, datactl_ena}), 32'd0);
        chk("abort_pc", 32'(pc), 32'h000);
        sb.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
Fetch/decode/execute sequencer for the 8-bit RISC CPU, directly upstream of the ALU. It fetches 2-byte instructions over the shared 8-bit bus and drives the ALU opcode. It also generates memory strobes and the accumulator load strobe. It owns the PC, the instruction register and a small return-address stack for ACL/RET.

Parameters:
ADDR_W, 12, bus address width; fixed by the instruction format: byte0 = {op[3:0], addr[11:8]}, byte1 = addr[7:0].
STACK_DEPTH, 4, return-stack entries; must be a power of 2, at least 2.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  run enable, sampled only in S_F0
data_in  in  8  bus read data, ROM/RAM
addr  out  ADDR_W  bus address
rd  out  1  bus read strobe
wr  out  1  bus write strobe
datactl_ena  out  1  drive accumulator onto bus (STO)
alu_op  out  4  opcode to ALU op input
load_acc  out  1  accumulator captures alu_out at this clock edge
halt  out  1  CPU halted
pc  out  ADDR_W  current PC (debug)

Behaviour:
- Reset (async, rst_n=0):
  - State S_F0; pc=0, ir=0, sp=0.
  - addr=0, rd=wr=datactl_ena=load_acc=halt=0, alu_op=4'b0000.
  - Reset mid-instruction aborts it; wr drops immediately.
- Opcode map: NOP 0, LDO 1, LDA 2, STO 3, PRE 4, JMP 5, ADD 6, SUB 7, LAND 8, LOR 9, LNOT A, INC B, ACL C, RET D, LDM E, HLT F.
- Fixed 5-cycle instruction: S_F0 -> S_F1 -> S_DEC -> S_EX -> S_WB -> S_F0.
- S_F0:
  - If ena=0: stay in S_F0, rd=0, pc holds.
  - Else addr=pc, rd=1; at the edge ir[15:8]<=data_in, pc<=pc+1.
- S_F1: addr=pc, rd=1; at the edge ir[7:0]<=data_in, pc<=pc+1.
- S_DEC: no bus activity; alu_op=ir[15:12]. HLT -> S_HALT, otherwise -> S_EX.
- alu_op:
  - Equals ir op in S_DEC, S_EX and S_WB.
  - Is 4'b0000 in S_F0, S_F1 and S_HALT, so the ALU passes accum through.
- S_EX and S_WB by op class (ir_addr = ir[11:0]):
  - LDO/LDA/PRE/ADD/SUB/LAND/LOR: addr=ir_addr, rd=1 in both S_EX and S_WB; load_acc=1 only in S_WB.
  - LNOT/INC: no bus activity; load_acc=1 in S_WB.
  - STO: addr=ir_addr, wr=1 and datactl_ena=1 in S_EX only; S_WB idle.
  - JMP: pc<=ir_addr at the end of S_EX.
  - ACL: stack[sp]<=pc (address of next instruction), sp<=sp+1, pc<=ir_addr at the end of S_EX.
  - RET: sp<=sp-1, pc<=stack[sp-1] at the end of S_EX.
  - NOP/LDM: no bus activity, load_acc=0.
- Outside the cases above, rd, wr, datactl_ena and load_acc are 0; all of them are registered outputs.
- S_HALT:
  - halt=1, all strobes 0, alu_op=0.
  - ena ignored; the only exit is rst_n.
- PC arithmetic is mod 2^ADDR_W: 0xFFF+1 -> 0x000, including the byte1 fetch wrap.
- Stack is circular; sp arithmetic is mod STACK_DEPTH. Overflow overwrites the oldest entry; underflow returns a stale entry.
- ena deasserted mid-instruction has no effect until the next S_F0.

Optional Feature:
CTRL_STACK_CHK_EN:
- Defined:
  - Adds output stack_err (1 bit, reset 0).
  - Keeps an occupancy count 0..STACK_DEPTH.
  - ACL when full, or RET when empty: no push/pop, pc unchanged, stack_err<=1, next state S_HALT.
  - stack_err is sticky until reset.
- Undefined: no stack_err port; wrap behaviour as above.

Test Plan:
- LDA: reset, ena=1, ROM[0]=0x20, ROM[1]=0x10, RAM[0x010]=0x5A -> addr 0x000, 0x001, -, 0x010, 0x010; rd=1,1,0,1,1; alu_op=2 in cycles 3-5; load_acc pulses in cycle 5; pc=0x002.
- STO: instruction 0x30,0x20 -> cycle 4: addr=0x020, wr=1, datactl_ena=1 for exactly one cycle; rd=0 throughout EX/WB.
- JMP/ACL/RET:
  - JMP 0x123 (0x51,0x23) -> next S_F0 addr=0x123.
  - ACL 0x200 at 0x010 -> fetch at 0x200.
  - RET there -> fetch resumes at 0x012.
- Halt and ena:
  - HLT (0xF0,0x00) -> halt=1 from the cycle after S_DEC; strobes stay 0 for 20 cycles despite ena toggling.
  - rst_n pulse -> halt=0, pc=0.
  - ena=0 in S_F0 for 3 cycles -> rd=0, pc held; ena=1 -> fetch resumes at the same pc.
- Stack overflow, depth 4, five nested ACL:
  - With CTRL_STACK_CHK_EN: stack_err=1 and halt=1 after the fifth, pc unchanged.
  - Without it: the fifth overwrites entry 0; five RETs return the 5th, 4th, 3rd, 2nd, then 5th addresses.
- PC wrap and reset abort:
  - Instruction at 0xFFF -> byte1 fetched from 0x000.
  - rst_n low during S_EX of STO -> wr falls without waiting for a clock edge.
